// File: rtl/rah_packet_deframer_if.sv
// Deframer bus: decoder-queue read side plus the payload stream toward the app.
// "master" is the deframer side and "slave" is the queue/application side.
interface rah_packet_deframer_if #(
  parameter int unsigned DATA_WIDTH = 48
);
  logic                  q_empty;
  logic                  request_data;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sop;
  logic                  out_eop;
  logic [7:0]            out_opcode;
  logic                  len_error;
  logic                  busy;

  modport master (
    input  q_empty, in_data, out_ready,
    output request_data, out_valid, out_data, out_sop, out_eop,
           out_opcode, len_error, busy
  );

  modport slave (
    output q_empty, in_data, out_ready,
    input  request_data, out_valid, out_data, out_sop, out_eop,
           out_opcode, len_error, busy
  );
endinterface

// File: rtl/rah_packet_deframer.sv
// Per-app deframer: pops a header and LEN payload words from a rah_decoder queue,
// then streams the payload through a 2-entry buffer with sop/eop framing.
module rah_packet_deframer #(
  parameter int unsigned DATA_WIDTH = 48,
  parameter int unsigned MAX_LEN    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  rah_packet_deframer_if.master bus
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DRAIN} state_e;

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [7:0]            opcode_q, opcode_d;
  logic                  first_q, first_d;
  // A pop issued last cycle: its word is on in_data this cycle.
  logic                  infl_q, infl_d;
  logic                  infl_sop_q, infl_sop_d;
  logic                  infl_eop_q, infl_eop_d;

  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [1:0]            buf_sop_q, buf_eop_q;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;

  logic [15:0]           hdr_len;
  logic [7:0]            hdr_opcode;
  logic                  out_valid, out_eop;
  logic                  owes, room, pop, deq, wr, len_err;

  assign hdr_len    = bus.in_data[15:0];
  assign hdr_opcode = bus.in_data[DATA_WIDTH-1 -: 8];

  assign out_valid  = occ_q != 2'd0;
  assign out_eop    = out_valid && buf_eop_q[rd_ptr_q];
  assign deq        = out_valid && bus.out_ready;
  assign wr         = infl_q && (state_q == PAYLOAD);
  assign owes       = ((state_q == PAYLOAD) || (state_q == DRAIN)) && (cnt_q != '0);
  // Buffered words plus the in-flight pop, less this cycle's acceptance, must leave a free slot.
  assign room       = (3'(occ_q) + 3'(infl_q)) < (3'd2 + 3'(deq));
  assign pop        = !reset && !bus.q_empty && ((state_q == IDLE) || owes) && room;

  assign bus.request_data = pop;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = buf_data_q[rd_ptr_q];
  assign bus.out_sop      = out_valid && buf_sop_q[rd_ptr_q];
  assign bus.out_eop      = out_eop;
  assign bus.out_opcode   = opcode_q;
  assign bus.len_error    = len_err;
  assign bus.busy         = (state_q != IDLE) || (occ_q != 2'd0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opcode_d   = opcode_q;
    first_d    = first_q;
    len_err    = 1'b0;
    infl_d     = pop;
    infl_sop_d = pop && first_q && (state_q == PAYLOAD);
    infl_eop_d = pop && (cnt_q == 16'd1);

    case (state_q)
      IDLE: begin
        if (pop) state_d = HDR;
      end
      HDR: begin
        if (hdr_len == '0) begin
          len_err = 1'b1;
          state_d = IDLE;
        end else if (hdr_len > MAX_LEN_W) begin
          len_err = 1'b1;
          cnt_d   = hdr_len;
          state_d = DRAIN;
        end else begin
          opcode_d = hdr_opcode;
          cnt_d    = hdr_len;
          first_d  = 1'b1;
          state_d  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (pop) begin
          cnt_d   = cnt_q - 16'd1;
          first_d = 1'b0;
        end
        if (deq && out_eop) state_d = IDLE;
      end
      DRAIN: begin
        if (pop) cnt_d = cnt_q - 16'd1;
        if (infl_q && infl_eop_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    occ_d    = occ_q + 2'(wr) - 2'(deq);
    wr_ptr_d = wr_ptr_q ^ wr;
    rd_ptr_d = rd_ptr_q ^ deq;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      opcode_q   <= '0;
      first_q    <= 1'b0;
      infl_q     <= 1'b0;
      infl_sop_q <= 1'b0;
      infl_eop_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opcode_q   <= opcode_d;
      first_q    <= first_d;
      infl_q     <= infl_d;
      infl_sop_q <= infl_sop_d;
      infl_eop_q <= infl_eop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) buf_data_q[i] <= '0;
      buf_sop_q <= '0;
      buf_eop_q <= '0;
    end else if (wr) begin
      buf_data_q[wr_ptr_q] <= bus.in_data;
      buf_sop_q[wr_ptr_q]  <= infl_sop_q;
      buf_eop_q[wr_ptr_q]  <= infl_eop_q;
    end
  end

  assert property (@(posedge clk) disable iff (reset) (3'(occ_q) + 3'(infl_q)) <= 3'd2);

endmodule

// File: tb/tb_rah_packet_deframer.sv
// Directed bench for rah_packet_deframer: a table of message scenarios with
// hand-computed expectations, plus hand-written reset sequences.
module tb_rah_packet_deframer;
  localparam int unsigned DW     = 48;
  localparam int unsigned TB_MAX = 8;
  localparam int          BUDGET = 400;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rah_packet_deframer_if #(.DATA_WIDTH(DW)) dif ();

  rah_packet_deframer #(.DATA_WIDTH(DW), .MAX_LEN(TB_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  typedef struct {
    string       name;
    logic [7:0]  opc_a;
    logic [15:0] len_a;
    logic [47:0] base_a;
    bit          has_b;
    logic [7:0]  opc_b;
    logic [15:0] len_b;
    logic [47:0] base_b;
    logic [3:0]  ready_pat;
    int          stall_at;
    int          stall_len;
    int          exp_words;
    int          exp_errs;
    int          exp_pops;
    int          exp_lat;
    int          exp_span;
  } vec_t;

  typedef struct {
    logic [47:0] data;
    logic [7:0]  opc;
    bit          sop;
    bit          eop;
  } exp_t;

  logic [47:0] qmem[$];
  int          qtag[$];   // 0 header, 1 forwarded payload, 2 discarded payload
  exp_t        expq[$];
  vec_t        vecs[7];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic load_msg(input logic [7:0] opc, input logic [15:0] len, input logic [47:0] base);
    bit          legal;
    logic [47:0] w;
    legal = (len != 16'd0) && (32'(len) <= TB_MAX);
    qmem.push_back({opc, 24'hC3C3C3, len});
    qtag.push_back(0);
    for (int k = 0; k < int'(len); k++) begin
      w = base + 48'(k);
      qmem.push_back(w);
      qtag.push_back(legal ? 1 : 2);
      if (legal) expq.push_back('{w, opc, k == 0, k == int'(len) - 1});
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_request_data"}, 64'(dif.request_data), 64'(0));
    chk({tag, "_out_valid"},    64'(dif.out_valid),    64'(0));
    chk({tag, "_out_sop"},      64'(dif.out_sop),      64'(0));
    chk({tag, "_out_eop"},      64'(dif.out_eop),      64'(0));
    chk({tag, "_len_error"},    64'(dif.len_error),    64'(0));
    chk({tag, "_busy"},         64'(dif.busy),         64'(0));
    chk({tag, "_out_data"},     64'(dif.out_data),     64'(0));
    chk({tag, "_out_opcode"},   64'(dif.out_opcode),   64'(0));
  endtask

  // Entered and left just after a rising edge.
  task automatic run_vec(input vec_t v);
    int c, pops, words, errs, hdr_c, first_hdr_c, first_v_c, last_acc_c, last_pop_c;
    int fwd_pops, max_out;
    bit pop, acc, done, hold;
    logic [47:0] hd;
    logic [7:0]  ho;
    logic        hs, he;
    exp_t e;
    expq.delete();
    load_msg(v.opc_a, v.len_a, v.base_a);
    if (v.has_b) load_msg(v.opc_b, v.len_b, v.base_b);
    pops = 0; words = 0; errs = 0; hdr_c = -10; first_hdr_c = -1; first_v_c = -1;
    last_acc_c = 0; last_pop_c = 0; fwd_pops = 0; max_out = 0;
    done = 1'b0; hold = 1'b0; hd = '0; ho = '0; hs = 1'b0; he = 1'b0;
    for (c = 0; c < BUDGET && !done; c++) begin
      dif.out_ready = v.ready_pat[c % 4];
      dif.q_empty   = ((c >= v.stall_at) && (c < v.stall_at + v.stall_len)) || (qmem.size() == 0);
      @(negedge clk);
      chk({v.name, "_no_pop_when_empty"}, 64'(dif.request_data & dif.q_empty), 64'(0));
      if (hold) begin
        chk({v.name, "_hold_valid"}, 64'(dif.out_valid),  64'(1));
        chk({v.name, "_hold_data"},  64'(dif.out_data),   64'(hd));
        chk({v.name, "_hold_opc"},   64'(dif.out_opcode), 64'(ho));
        chk({v.name, "_hold_sop"},   64'(dif.out_sop),    64'(hs));
        chk({v.name, "_hold_eop"},   64'(dif.out_eop),    64'(he));
      end
      pop = dif.request_data;
      acc = dif.out_valid && dif.out_ready;
      if (dif.out_valid && first_v_c < 0) first_v_c = c;
      if (dif.len_error) begin
        errs++;
        chk({v.name, "_len_err_cycle"}, 64'(c), 64'(hdr_c + 1));
      end
      if (acc) begin
        words++;
        last_acc_c = c;
        if (expq.size() == 0) flag_fail({v.name, "_extra_word"});
        else begin
          e = expq.pop_front();
          chk({v.name, "_data"}, 64'(dif.out_data),   64'(e.data));
          chk({v.name, "_opc"},  64'(dif.out_opcode), 64'(e.opc));
          chk({v.name, "_sop"},  64'(dif.out_sop),    64'(e.sop));
          chk({v.name, "_eop"},  64'(dif.out_eop),    64'(e.eop));
        end
      end
      if (pop) begin
        pops++;
        last_pop_c = c;
        if (qtag.size() > 0) begin
          if (qtag[0] == 0) begin
            hdr_c = c;
            if (first_hdr_c < 0) first_hdr_c = c;
          end else if (qtag[0] == 1) fwd_pops++;
        end
      end
      if (fwd_pops - words > max_out) max_out = fwd_pops - words;
      hold = dif.out_valid && !dif.out_ready;
      hd = dif.out_data; ho = dif.out_opcode; hs = dif.out_sop; he = dif.out_eop;
      done = (qmem.size() == 0) && !dif.busy && (c >= last_pop_c + 3);
      @(posedge clk);
      #1;
      if (pop) begin
        if (qmem.size() == 0) begin
          flag_fail({v.name, "_pop_underflow"});
          dif.in_data = 48'hDEADBEEFCAFE;
        end else begin
          dif.in_data = qmem.pop_front();
          void'(qtag.pop_front());
        end
      end else dif.in_data = 48'hDEADBEEFCAFE;
    end
    if (!done) flag_fail({v.name, "_timeout"});
    chk({v.name, "_word_count"}, 64'(words), 64'(v.exp_words));
    chk({v.name, "_exp_left"},   64'(expq.size()), 64'(0));
    chk({v.name, "_err_count"},  64'(errs),  64'(v.exp_errs));
    chk({v.name, "_pop_count"},  64'(pops),  64'(v.exp_pops));
    if (v.exp_lat > 0) chk({v.name, "_first_valid_lat"}, 64'(first_v_c - first_hdr_c), 64'(v.exp_lat));
    if (v.exp_span >= 0) chk({v.name, "_span"}, 64'(last_acc_c - first_v_c), 64'(v.exp_span));
    chk({v.name, "_outstanding_le2"}, 64'(max_out <= 2), 64'(1));
    chk({v.name, "_busy_end"}, 64'(dif.busy), 64'(0));
    qmem.delete();
    qtag.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc_n;
    bit   pop;
    exp_t e;
    vec_t fresh;

    //        name                opc    len     base    b  opcB   lenB   baseB  rdy      st sl words err pops lat span
    vecs[0] = '{"len3",          8'h5A, 16'd3,  48'h100, 0, 8'h00, 16'd0, 48'h0,  4'b1111, 0, 0, 3, 0, 4,  4,  2};
    vecs[1] = '{"len1",          8'h33, 16'd1,  48'h110, 0, 8'h00, 16'd0, 48'h0,  4'b1111, 0, 0, 1, 0, 2,  4,  0};
    vecs[2] = '{"len8_bp_stall", 8'hC3, 16'd8,  48'h120, 0, 8'h00, 16'd0, 48'h0,  4'b1001, 6, 5, 8, 0, 9,  4, -1};
    vecs[3] = '{"len0_len2",     8'h11, 16'd0,  48'h130, 1, 8'h22, 16'd2, 48'h140, 4'b1111, 0, 0, 2, 1, 4,  6,  1};
    vecs[4] = '{"drain9_len2",   8'h44, 16'd9,  48'h150, 1, 8'h55, 16'd2, 48'h170, 4'b1111, 0, 0, 2, 1, 13, 16, 1};
    vecs[5] = '{"len_max",       8'hA5, 16'd8,  48'h180, 0, 8'h00, 16'd0, 48'h0,  4'b1111, 0, 0, 8, 0, 9,  4,  7};
    vecs[6] = '{"slow_stall",    8'h0F, 16'd2,  48'h190, 0, 8'h00, 16'd0, 48'h0,  4'b1000, 0, 3, 2, 0, 3,  4,  4};
    fresh   = '{"after_reset",   8'h77, 16'd2,  48'h600, 0, 8'h00, 16'd0, 48'h0,  4'b1111, 0, 0, 2, 0, 3,  4,  1};

    reset = 1'b1;
    dif.q_empty = 1'b0;
    dif.in_data = '0;
    dif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    @(posedge clk);
    #1;
    reset = 1'b0;
    dif.q_empty = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset lands after the second word of a LEN=5 message while words are still queued.
    expq.delete();
    load_msg(8'h66, 16'd5, 48'h500);
    dif.out_ready = 1'b1;
    acc_n = 0;
    for (int c = 0; c < 40 && acc_n < 2; c++) begin
      dif.q_empty = qmem.size() == 0;
      @(negedge clk);
      pop = dif.request_data;
      if (dif.out_valid && dif.out_ready) begin
        acc_n++;
        e = expq.pop_front();
        chk("rst_pre_data", 64'(dif.out_data), 64'(e.data));
        chk("rst_pre_sop",  64'(dif.out_sop),  64'(e.sop));
      end
      @(posedge clk);
      #1;
      if (pop && qmem.size() > 0) begin
        dif.in_data = qmem.pop_front();
        void'(qtag.pop_front());
      end
    end
    chk("rst_pre_words", 64'(acc_n), 64'(2));
    chk("rst_pre_q_empty", 64'(dif.q_empty), 64'(0));
    #1 reset = 1'b1;
    #1;
    chk_reset_outputs("mid");
    @(posedge clk);
    #1;
    reset = 1'b0;
    qmem.delete();
    qtag.delete();
    expq.delete();
    dif.q_empty = 1'b1;
    dif.in_data = 48'hDEADBEEFCAFE;
    @(posedge clk);
    #1;
    run_vec(fresh);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
